// File: rtl/strobe_tagger_n.sv
// Multi-channel strobe timestamper: synchronises strobe inputs, tags rising edges with a free-running
// timer and queues merged records in a FIFO with a ready/valid output port.
module strobe_tagger_n #(
  parameter int unsigned N_CHANNELS   = 4,
  parameter int unsigned TIME_WIDTH   = 36,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned WRAP_MARKERS = 1,
  localparam int unsigned RW          = 1 + N_CHANNELS + TIME_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CHANNELS-1:0] strobe_in,
  input  logic [N_CHANNELS-1:0] channel_en,
  input  logic                  capture_en,
  input  logic                  counter_reset,
  output logic [TIME_WIDTH-1:0] timer,
  output logic [RW-1:0]         record_data,
  output logic                  record_valid,
  input  logic                  record_ready,
  output logic [15:0]           lost_count
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  // Input synchronisers and edge detection
  logic [N_CHANNELS-1:0] sync1_q, sync2_q, prev_q;
  logic [N_CHANNELS-1:0] rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= strobe_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q & channel_en & {N_CHANNELS{capture_en}};

  // Timer
  logic [TIME_WIDTH-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (counter_reset) begin
      timer_d = '0;
    end else if (capture_en) begin
      timer_d = timer_q + TIME_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign timer = timer_q;

  // Record generation
  logic          wrap_hit;
  logic          gen;
  logic [RW-1:0] rec;

  assign wrap_hit = (WRAP_MARKERS != 0) && capture_en && (timer_q == '1);
  assign gen      = (|rise) || wrap_hit;
  assign rec      = {wrap_hit, rise, timer_q};

  // Record buffer: storage array plus a registered head slot; the head slot counts toward
  // FIFO_DEPTH so total capacity is exactly FIFO_DEPTH records.
  logic [RW-1:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] mem_cnt_q, mem_cnt_d;
  logic [CntW-1:0] total;
  logic            out_valid_q, out_valid_d;
  logic [RW-1:0]   out_data_q, out_data_d;
  logic            pop, full, accept, load;

  assign pop    = out_valid_q & record_ready;
  assign total  = mem_cnt_q + CntW'(out_valid_q);
  assign full   = (total == CntW'(FIFO_DEPTH));
  assign accept = gen && (!full || pop);
  assign load   = (!out_valid_q || pop) && (mem_cnt_q != '0);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    mem_cnt_d   = mem_cnt_q + CntW'(accept) - CntW'(load);
    if (accept) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (load) begin
      rd_ptr_d    = rd_ptr_q + PtrW'(1);
      out_valid_d = 1'b1;
      out_data_d  = mem_q[rd_ptr_q];
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= rec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign record_valid = out_valid_q;
  assign record_data  = out_data_q;

  // Dropped-record counter, saturating
  logic [15:0] lost_q, lost_d;

  always_comb begin
    lost_d = lost_q;
    if (counter_reset) begin
      lost_d = '0;
    end else if (gen && !accept && (lost_q != 16'hFFFF)) begin
      lost_d = lost_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lost_q <= '0;
    end else begin
      lost_q <= lost_d;
    end
  end

  assign lost_count = lost_q;

endmodule
